game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD digits, range 1..8.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000: input clock frequency.
REQ-003 SHALL have parameter TICK_HZ, default 1: count rate; PRESCALE = CLK_HZ/TICK_HZ, at least 2.
REQ-004 SHALL have port Clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: level; begin or resume counting.
REQ-007 SHALL have port pause, input, 1: level; freeze the count.
REQ-008 SHALL have port clear, input, 1: pulse; return to IDLE with count zero.
REQ-009 SHALL have port load, input, 1: pulse; take load_value as the count.
REQ-010 SHALL have port load_value, input, 4*DIGITS: BCD preset, digit 0 in bits [3:0].
REQ-011 SHALL have port count_down, input, 1: 1 = decrement, 0 = increment; sampled only on the IDLE->RUN transition.
REQ-012 SHALL have port bcd, output, 4*DIGITS: current count, for the HexDriver instances.
REQ-013 SHALL have port running, output, 1: high in RUN.
REQ-014 SHALL have port expired, output, 1: high in EXPIRED.
REQ-015 SHALL have port tick, output, 1: one-cycle pulse on each count update.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSED and EXPIRED.
REQ-017 SHALL use these transitions:
- IDLE->RUN on start, latching the direction.
- RUN->PAUSED on pause.
- PAUSED->RUN on start with pause low.
- RUN->EXPIRED on the terminal count.
REQ-018 SHALL apply same-cycle priority clear > load > pause > start.
REQ-019 SHALL, on clear, zero bcd and the prescaler and enter IDLE, whatever the state.
REQ-020 SHALL, on load, write load_value to bcd, zero the prescaler and enter IDLE, whatever the state.
REQ-021 SHALL clamp any load_value digit above 9 to 9.
REQ-022 SHALL count the prescaler 0..PRESCALE-1 only in RUN, holding its value in PAUSED.
REQ-023 SHALL, on prescaler wrap in RUN, pulse tick and update bcd on that same edge (PRESCALE cycles per count).
REQ-024 SHALL, in up mode, increment the digits with decimal carry (9->0 carries into the next digit).
REQ-025 SHALL, in down mode, decrement the digits with decimal borrow (0->9 borrows from the next digit).
REQ-026 SHALL detect the terminal count as follows:
- Up mode: the update that produces all digits 9 enters EXPIRED on that edge.
- Down mode: the update that produces all digits 0 enters EXPIRED.
REQ-027 SHALL, on start from IDLE with bcd already terminal for the latched direction, enter EXPIRED directly with no tick.
REQ-028 SHALL hold bcd in EXPIRED; exit only by clear or load.
REQ-029 SHALL ignore start and pause in EXPIRED.
REQ-030 SHALL drive running, expired and tick from registers, with zero added latency after the state or count edge.

Reset
REQ-031 SHALL, on Reset high at a Clk edge, set the following, overriding every other input:
- state IDLE
- bcd all 0
- prescaler 0
- tick 0
- running 0
- expired 0
- latched direction up

Structure
REQ-032 SHALL take the state enum and DIGIT_W = 4 from the shared package game_pkg.
REQ-033 SHALL instantiate DIGITS copies of the sub-module bcd_digit, chained by carry/borrow.
- Inputs: en, dir, load, d.
- Outputs: q, carry_out (q==9 up / q==0 down).
REQ-034 SHALL keep the prescaler width at $clog2(PRESCALE).

Verification (DIGITS=3, CLK_HZ=10, TICK_HZ=1 unless noted)
REQ-035 SHALL verify up count: Reset, then start held in up mode -> first tick 10 cycles after RUN; bcd 000 -> 001 -> 002; after 10 ticks bcd = 010.
REQ-036 SHALL verify down expiry: load 0x002, count_down=1, start -> ticks give 001 then 000; expired=1 on the same edge; running=0; bcd holds 000 for 50 further cycles.
REQ-037 SHALL verify up saturation: load 0x998, up, start -> 999 with expired=1; no further ticks.
REQ-038 SHALL verify pause: start, pause asserted at prescaler = 6 for 20 cycles -> bcd frozen, no tick; next tick 4 cycles after resume.
REQ-039 SHALL verify same-cycle priority: clear and load asserted together mid-RUN -> bcd 000, IDLE; load 0x5F3 -> bcd 0x593.
REQ-040 SHALL verify reset mid-operation: Reset during RUN at bcd 0x047 -> next cycle bcd 000, running 0, and start then resumes from 000 in up mode.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the game timer.
//   state_t     : controller states (IDLE, RUN, PAUSED, EXPIRED)
//   DIGIT_W     : width of one BCD digit
//   clamp_digit : limits a raw nibble to a legal BCD digit (0..9)
package game_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 4'd0;
   localparam logic [DIGIT_W-1:0] DIGIT_NINE = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v);
      return (v > DIGIT_NINE) ? DIGIT_NINE : v;
   endfunction

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One decade of the BCD counter chain.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, clears the digit
//   en        : step this digit by one (up or down per dir)
//   dir       : 0 = increment, 1 = decrement
//   load      : take d as the new digit value (beats en)
//   d         : value written on load
//   q         : current digit value
//   carry_out : digit is at its rollover point (9 when up, 0 when down),
//               so the next step ripples into the following digit
module bcd_digit
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               dir,
   input  logic               load,
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q,
   output logic               carry_out
);

   assign carry_out = dir ? (q == DIGIT_ZERO) : (q == DIGIT_NINE);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= DIGIT_ZERO;
      end else if (load) begin
         q <= d;
      end else if (en) begin
         if (dir) begin
            q <= (q == DIGIT_ZERO) ? DIGIT_NINE : q - 4'd1;
         end else begin
            q <= (q == DIGIT_NINE) ? DIGIT_ZERO : q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/game_timer.sv
// BCD game timer: counts up or down at TICK_HZ, with start/pause/clear/load
// control and saturation at the terminal count.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | stopped; count holds the cleared or loaded value
// RUN     | prescaler running, count updates on every wrap
// PAUSED  | prescaler and count frozen, resumes on start with pause low
// EXPIRED | terminal count reached; only clear or load leave this state
//
// Ports:
//   Clk        : clock, all logic on the rising edge
//   Reset      : synchronous active-high reset
//   start      : level, begin (IDLE) or resume (PAUSED) counting
//   pause      : level, freeze the count while running
//   clear      : pulse, zero the count and return to IDLE
//   load       : pulse, take load_value (digits clamped to 9) and go IDLE
//   load_value : BCD preset, digit 0 in bits [3:0]
//   count_down : direction, captured on the IDLE->RUN transition
//   bcd        : current count
//   running    : high while in RUN
//   expired    : high while in EXPIRED
//   tick       : one-cycle pulse on each count update
module game_timer
   import game_pkg::*;
#(
   parameter int DIGITS  = 3,
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   clear,
   input  logic                   load,
   input  logic [4*DIGITS-1:0]    load_value,
   input  logic                   count_down,
   output logic [4*DIGITS-1:0]    bcd,
   output logic                   running,
   output logic                   expired,
   output logic                   tick
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int PS_W     = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   state_t              state;
   logic [PS_W-1:0]     prescaler;
   logic                dir;

   logic                ps_wrap;
   logic                advance;
   logic                digit_load;
   logic [DIGITS-1:0]   digit_en;
   logic [DIGITS-1:0]   carry;
   logic [4*DIGITS-1:0] load_data;

   logic                all_nine;
   logic                all_zero;
   logic                upper_term;
   logic                last_step;
   logic                start_term;

   assign ps_wrap    = (prescaler == PS_LAST);
   assign advance    = (state == ST_RUN) && !clear && !load && !pause && ps_wrap;
   assign digit_load = clear | load;

   // Digit chain: digit 0 steps on every count update, each higher digit
   // steps only when every digit below it is rolling over.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign load_data[i*DIGIT_W +: DIGIT_W] =
         clear ? DIGIT_ZERO : clamp_digit(load_value[i*DIGIT_W +: DIGIT_W]);

      if (i == 0) begin : g_first
         assign digit_en[i] = advance;
      end else begin : g_rest
         assign digit_en[i] = digit_en[i-1] & carry[i-1];
      end

      bcd_digit u_digit (
         .clk       (Clk),
         .reset     (Reset),
         .en        (digit_en[i]),
         .dir       (dir),
         .load      (digit_load),
         .d         (load_data[i*DIGIT_W +: DIGIT_W]),
         .q         (bcd[i*DIGIT_W +: DIGIT_W]),
         .carry_out (carry[i])
      );
   end

   // Terminal detection. While running, the update that lands on the
   // terminal value is the one where all upper digits already sit at their
   // rollover value (carry reflects the latched direction) and digit 0 is
   // one step away. At start the direction is not latched yet, so the
   // incoming count_down is used against the full count instead.
   always_comb begin
      all_nine   = 1'b1;
      all_zero   = 1'b1;
      upper_term = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         all_nine = all_nine & (bcd[i*DIGIT_W +: DIGIT_W] == DIGIT_NINE);
         all_zero = all_zero & (bcd[i*DIGIT_W +: DIGIT_W] == DIGIT_ZERO);
         if (i > 0) begin
            upper_term = upper_term & carry[i];
         end
      end
      last_step  = upper_term &
                   (dir ? (bcd[DIGIT_W-1:0] == 4'd1) : (bcd[DIGIT_W-1:0] == 4'd8));
      start_term = count_down ? all_zero : all_nine;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_IDLE;
         prescaler <= '0;
         dir       <= 1'b0;
         tick      <= 1'b0;
         running   <= 1'b0;
         expired   <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clear || load) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            running   <= 1'b0;
            expired   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !pause) begin
                     dir <= count_down;
                     if (start_term) begin
                        state   <= ST_EXPIRED;
                        expired <= 1'b1;
                     end else begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                     end
                  end
               end
               ST_RUN: begin
                  if (pause) begin
                     state   <= ST_PAUSED;
                     running <= 1'b0;
                  end else if (ps_wrap) begin
                     prescaler <= '0;
                     tick      <= 1'b1;
                     if (last_step) begin
                        state   <= ST_EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
                     end
                  end else begin
                     prescaler <= prescaler + PS_W'(1);
                  end
               end
               ST_PAUSED: begin
                  if (start && !pause) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_EXPIRED: begin
                  state <= ST_EXPIRED;
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                  expired <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

   localparam int PRESCALE = 10;
   localparam int MAXV     = 999;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        clr = 1'b0;
   logic        ld = 1'b0;
   logic        cdn = 1'b0;
   logic [11:0] ld_val = '0;
   logic [11:0] bcd;
   logic        running;
   logic        expired;
   logic        tick;

   int tests = 0;
   int fails = 0;

   // reference model: integer count, abstract mode, prescaler phase
   int m_cnt = 0;
   int m_ps = 0;
   int m_mode = M_IDLE;
   bit m_down = 1'b0;
   bit m_tick = 1'b0;

   game_timer #(.DIGITS(3), .CLK_HZ(10), .TICK_HZ(1)) dut (
      .Clk        (clk),
      .Reset      (rst),
      .start      (start),
      .pause      (pause),
      .clear      (clr),
      .load       (ld),
      .load_value (ld_val),
      .count_down (cdn),
      .bcd        (bcd),
      .running    (running),
      .expired    (expired),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'((v / 100) % 10);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      return {d2, d1, d0};
   endfunction

   function automatic int load_to_int(input logic [11:0] v);
      int r;
      int d;
      r = 0;
      for (int i = 2; i >= 0; i--) begin
         d = int'(v[i*4 +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic bit at_end(input int v, input bit down);
      return down ? (v == 0) : (v == MAXV);
   endfunction

   task automatic model_update();
      m_tick = 1'b0;
      if (rst) begin
         m_mode = M_IDLE; m_cnt = 0; m_ps = 0; m_down = 1'b0;
      end else if (clr) begin
         m_mode = M_IDLE; m_cnt = 0; m_ps = 0;
      end else if (ld) begin
         m_mode = M_IDLE; m_cnt = load_to_int(ld_val); m_ps = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (start && !pause) begin
               m_down = cdn;
               m_mode = at_end(m_cnt, m_down) ? M_EXPIRED : M_RUN;
            end
            M_RUN: begin
               if (pause) m_mode = M_PAUSED;
               else if (m_ps == PRESCALE - 1) begin
                  m_ps = 0;
                  m_tick = 1'b1;
                  m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
                  if (at_end(m_cnt, m_down)) m_mode = M_EXPIRED;
               end else m_ps++;
            end
            M_PAUSED: if (start && !pause) m_mode = M_RUN;
            default: ;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0; ld = 1'b0; cdn = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (tick !== 1'b1 && n < 40);
   endtask

   task automatic do_clear();
      idle_inputs();
      clr = 1'b1; step(); clr = 1'b0;
   endtask

   task automatic do_load(input logic [11:0] v);
      ld = 1'b1; ld_val = v; step(); ld = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b1; ld = 1'b1; ld_val = 12'h123; cdn = 1'b1; rst = 1'b1;
      step(); step();
      tests++; if (bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd got %h want 000", bcd); end
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running got %b want 0", running); end
      tests++; if (expired !== 1'b0) begin fails++; $display("FAIL reset_expired got %b want 0", expired); end
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", tick); end
      idle_inputs();
      step();
   endtask

   task automatic test_up_count();
      int n;
      idle_inputs(); rst = 1'b1; step(); rst = 1'b0;
      start = 1'b1; cdn = 1'b0; step();
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL up_running got %b want 1", running); end
      wait_tick(n);
      tests++; if (n !== 10) begin fails++; $display("FAIL up_first_latency got %0d want 10", n); end
      tests++; if (bcd !== 12'h001) begin fails++; $display("FAIL up_first_bcd got %h want 001", bcd); end
      wait_tick(n);
      tests++; if (bcd !== 12'h002 || n !== 10) begin fails++; $display("FAIL up_second got bcd %h after %0d want 002 after 10", bcd, n); end
      repeat (8) wait_tick(n);
      tests++; if (bcd !== 12'h010) begin fails++; $display("FAIL up_tenth_bcd got %h want 010", bcd); end
   endtask

   task automatic test_down_expiry();
      int n, ticks, bad;
      do_clear();
      do_load(12'h002);
      cdn = 1'b1; start = 1'b1; step();
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL down_running got %b want 1", running); end
      wait_tick(n);
      tests++; if (bcd !== 12'h001 || expired !== 1'b0 || n !== 10) begin fails++; $display("FAIL down_first got bcd %h exp %b lat %0d want 001 0 10", bcd, expired, n); end
      wait_tick(n);
      tests++; if (bcd !== 12'h000) begin fails++; $display("FAIL down_zero_bcd got %h want 000", bcd); end
      tests++; if (expired !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL down_expire_flags got exp %b run %b want 1 0", expired, running); end
      ticks = 0; bad = 0;
      repeat (50) begin
         step();
         if (tick === 1'b1) ticks++;
         if (bcd !== 12'h000 || expired !== 1'b1) bad++;
      end
      tests++; if (ticks !== 0 || bad !== 0) begin fails++; $display("FAIL down_hold got ticks %0d bad %0d want 0 0", ticks, bad); end
   endtask

   task automatic test_up_saturation();
      int n, ticks;
      do_clear();
      do_load(12'h998);
      cdn = 1'b0; start = 1'b1; step();
      wait_tick(n);
      tests++; if (bcd !== 12'h999 || expired !== 1'b1 || n !== 10) begin fails++; $display("FAIL sat_bcd got %h exp %b lat %0d want 999 1 10", bcd, expired, n); end
      ticks = 0;
      pause = 1'b1;
      repeat (5) begin step(); if (tick === 1'b1) ticks++; end
      pause = 1'b0;
      repeat (25) begin step(); if (tick === 1'b1) ticks++; end
      tests++; if (ticks !== 0 || bcd !== 12'h999 || expired !== 1'b1) begin fails++; $display("FAIL sat_hold got ticks %0d bcd %h exp %b want 0 999 1", ticks, bcd, expired); end
      // start from IDLE on an already-terminal count expires without a tick
      do_load(12'h999); start = 1'b1; step();
      tests++; if (expired !== 1'b1 || tick !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL sat_direct got exp %b tick %b run %b want 1 0 0", expired, tick, running); end
   endtask

   task automatic test_pause();
      int n, ticks, bad;
      do_clear();
      start = 1'b1; cdn = 1'b0; step();
      repeat (6) step();
      pause = 1'b1;
      ticks = 0; bad = 0;
      repeat (20) begin
         step();
         if (tick === 1'b1) ticks++;
         if (bcd !== 12'h000 || running !== 1'b0) bad++;
      end
      tests++; if (ticks !== 0 || bad !== 0) begin fails++; $display("FAIL pause_frozen got ticks %0d bad %0d want 0 0", ticks, bad); end
      pause = 1'b0; step();
      tests++; if (running !== 1'b1) begin fails++; $display("FAIL pause_resume got %b want 1", running); end
      wait_tick(n);
      tests++; if (n !== 4 || bcd !== 12'h001) begin fails++; $display("FAIL pause_next_tick got lat %0d bcd %h want 4 001", n, bcd); end
   endtask

   task automatic test_priority();
      int n;
      do_clear();
      start = 1'b1; cdn = 1'b0; step();
      wait_tick(n); wait_tick(n);
      repeat (3) step();
      clr = 1'b1; ld = 1'b1; ld_val = 12'h777; pause = 1'b1;
      step();
      clr = 1'b0; ld = 1'b0; pause = 1'b0;
      tests++; if (bcd !== 12'h000 || running !== 1'b0 || expired !== 1'b0) begin fails++; $display("FAIL prio_clear got bcd %h run %b exp %b want 000 0 0", bcd, running, expired); end
      ld = 1'b1; ld_val = 12'h5F3; start = 1'b1;
      step();
      ld = 1'b0; start = 1'b0;
      tests++; if (bcd !== 12'h593 || running !== 1'b0) begin fails++; $display("FAIL prio_load_clamp got bcd %h run %b want 593 0", bcd, running); end
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      do_clear();
      do_load(12'h049);
      cdn = 1'b1; start = 1'b1; step();
      wait_tick(n); wait_tick(n);
      tests++; if (bcd !== 12'h047) begin fails++; $display("FAIL rmid_pre got %h want 047", bcd); end
      repeat (3) step();
      rst = 1'b1; step(); rst = 1'b0;
      tests++; if (bcd !== 12'h000 || running !== 1'b0 || expired !== 1'b0) begin fails++; $display("FAIL rmid_reset got bcd %h run %b exp %b want 000 0 0", bcd, running, expired); end
      cdn = 1'b0; start = 1'b1; step();
      wait_tick(n);
      tests++; if (bcd !== 12'h001 || n !== 10) begin fails++; $display("FAIL rmid_resume got bcd %h lat %0d want 001 10", bcd, n); end
   endtask

   task automatic test_random();
      int r;
      idle_inputs(); rst = 1'b1; step(); rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 999);
         rst = (r < 3);
         clr = (r >= 3 && r < 20);
         ld = (r >= 20 && r < 50);
         case ($urandom_range(0, 5))
            0: ld_val = 12'h998;
            1: ld_val = 12'h001;
            2: ld_val = 12'h002;
            3: ld_val = 12'h000;
            4: ld_val = 12'h999;
            default: ld_val = 12'($urandom);
         endcase
         if ($urandom_range(0, 11) == 0) pause = ~pause;
         start = ($urandom_range(0, 3) != 0);
         cdn = $urandom_range(0, 1) != 0;
         step();
         tests++; if (bcd !== to_bcd(m_cnt)) begin fails++; $display("FAIL rand_bcd cycle %0d got %h want %h", c, bcd, to_bcd(m_cnt)); end
         tests++; if (running !== (m_mode == M_RUN)) begin fails++; $display("FAIL rand_running cycle %0d got %b want %b", c, running, m_mode == M_RUN); end
         tests++; if (expired !== (m_mode == M_EXPIRED)) begin fails++; $display("FAIL rand_expired cycle %0d got %b want %b", c, expired, m_mode == M_EXPIRED); end
         tests++; if (tick !== m_tick) begin fails++; $display("FAIL rand_tick cycle %0d got %b want %b", c, tick, m_tick); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_expiry();
      test_up_saturation();
      test_pause();
      test_priority();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
